// File: rtl/slc3_button_ctrl.sv
// SLC-3 Run/Continue button front end: 2-flop synchronizers, optional debounce
// (enable with `define SLC3_BTN_DEBOUNCE_EN), press strobes and run/pause FSM.
module slc3_button_ctrl #(
  parameter int DB_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic       Pause_Req,
  output logic       Run_Pulse,
  output logic       Cont_Pulse,
  output logic       Cpu_Go,
  output logic       Paused,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    RESUME = 2'b11
  } state_t;

  state_t     state_q, state_d;

  // Bit 0 carries Run, bit 1 carries Continue; all levels are active-low.
  logic [1:0] btn_raw;
  logic [1:0] sync_p0, sync_p1;
  logic [1:0] db_lvl;
  logic [1:0] db_dly_p2;
  logic [1:0] pulse_p3;

  assign btn_raw = {Continue, Run};

  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_range
    $error("slc3_button_ctrl: DB_CYCLES must be in 1..255");
  end

  // Stage 0/1: two-flop synchronizer, parked at released (1).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef SLC3_BTN_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic [7:0] cnt_p2 [2];

  // Stage 2: a level is accepted only after DB_CYCLES disagreeing samples in a row.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      db_lvl    <= '1;
      cnt_p2[0] <= '0;
      cnt_p2[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync_p1[b] == db_lvl[b]) begin
          cnt_p2[b] <= '0;
        end else if (cnt_p2[b] == DB_LAST) begin
          db_lvl[b] <= sync_p1[b];
          cnt_p2[b] <= '0;
        end else begin
          cnt_p2[b] <= cnt_p2[b] + 8'd1;
        end
      end
    end
  end
`else
  assign db_lvl = sync_p1;
`endif

  // Stage 3: one-cycle strobe on each accepted 1->0 transition.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      db_dly_p2 <= '1;
      pulse_p3  <= '0;
    end else begin
      db_dly_p2 <= db_lvl;
      pulse_p3  <= db_dly_p2 & ~db_lvl;
    end
  end

  assign Run_Pulse  = pulse_p3[0];
  assign Cont_Pulse = pulse_p3[1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // RESUME waits for the CPU to leave its pause state, so one press gives one step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Run_Pulse)  state_d = RUN;
      RUN:     if (Pause_Req)  state_d = PAUSE;
      PAUSE:   if (Cont_Pulse) state_d = RESUME;
      RESUME:  if (!Pause_Req) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign Cpu_Go = (state_q == RUN) || (state_q == RESUME);
  assign Paused = (state_q == PAUSE);
  assign State  = state_q;

endmodule

// File: doc/slc3_button_ctrl.md
SLC3_BUTTON_CTRL -- requirements
Module: slc3_button_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4: consecutive identical synchronized samples needed to accept a new button level (range 1..255).
REQ-002 SHALL have port Clk, input, 1, single system clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port Run, input, 1, asynchronous active-low Run push-button (0 = pressed).
REQ-005 SHALL have port Continue, input, 1, asynchronous active-low Continue push-button (0 = pressed).
REQ-006 SHALL have port Pause_Req, input, 1, synchronous level from the SLC-3 control unit; 1 = CPU is sitting in a pause state.
REQ-007 SHALL have port Run_Pulse, output, 1, one-cycle strobe on each accepted Run press.
REQ-008 SHALL have port Cont_Pulse, output, 1, one-cycle strobe on each accepted Continue press.
REQ-009 SHALL have port Cpu_Go, output, 1, level; 1 = CPU may advance.
REQ-010 SHALL have port Paused, output, 1, level; 1 = FSM in PAUSE.
REQ-011 SHALL have port State, output, 2, FSM encoding: IDLE=00, RUN=01, PAUSE=10, RESUME=11.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer; both flops reset to 1 (released).
REQ-013 SHALL keep one debounced level per button; it changes only after DB_CYCLES consecutive synchronizer outputs differing from it; any matching sample clears the counter.
REQ-014 SHALL assert a button's pulse for exactly one cycle, in the cycle after its debounced level goes 1->0; a release (0->1) produces no pulse; a held button produces one pulse only.
REQ-015 SHALL give press-to-pulse latency of exactly 2+DB_CYCLES rising edges after the first edge sampling the button low, provided the button is held stable.
REQ-016 SHALL reject glitches: a low excursion shorter than DB_CYCLES synchronized samples produces no pulse.
REQ-017 SHALL run the FSM on pulses; transitions occur on the edge where the pulse is high.
REQ-018 SHALL in IDLE: Cpu_Go=0; Run_Pulse -> RUN; Cont_Pulse ignored.
REQ-019 SHALL in RUN: Cpu_Go=1; Pause_Req=1 -> PAUSE; Run_Pulse and Cont_Pulse ignored.
REQ-020 SHALL in PAUSE: Cpu_Go=0, Paused=1; Cont_Pulse -> RESUME; Run_Pulse ignored.
REQ-021 SHALL in RESUME: Cpu_Go=1; Pause_Req=0 -> RUN; additional Cont_Pulse ignored. This handshake guarantees one step per Continue press.
REQ-022 SHALL, when Run_Pulse and Cont_Pulse are high in the same cycle, apply only the pulse legal in the current state, so no conflict exists.
REQ-023 SHALL derive Cpu_Go and Paused combinationally from the state register only.

Reset
REQ-024 SHALL, on Reset=1 at any time, including mid-debounce or in PAUSE, immediately force: FSM=IDLE, counters=0, synchronizers and debounced levels=1, Run_Pulse=0, Cont_Pulse=0, Cpu_Go=0, Paused=0, State=00.
REQ-025 SHALL, after Reset deasserts with a button already held low, treat the press as new and pulse after 2+DB_CYCLES edges.

Configuration
REQ-026 SHALL with macro SLC3_BTN_DEBOUNCE_EN defined, include the debounce counters of REQ-013, REQ-015 and REQ-016.
REQ-027 SHALL with SLC3_BTN_DEBOUNCE_EN undefined, remove the counters and ignore DB_CYCLES; the debounced level equals the synchronizer output, so latency is 2 edges and no glitch rejection exists. All FSM behaviour is unchanged.

Verification (DB_CYCLES=4, macro defined unless stated)
REQ-028 SHALL cover: Reset, then Run low at edge 0 and held 20 cycles -> single Run_Pulse at edge 6; State 00->01; Cpu_Go=1 from edge 7.
REQ-029 SHALL cover: Continue low for 2 cycles, then high -> no Cont_Pulse; State unchanged.
REQ-030 SHALL cover: in RUN, Pause_Req=1 -> State=10, Paused=1, Cpu_Go=0; then Continue pressed -> State=11, Cpu_Go=1; Pause_Req=0 -> State=01; a second Continue press while still in RESUME has no effect.
REQ-031 SHALL cover: in PAUSE, Run and Continue pressed on the same edge -> State=11; Run press ignored.
REQ-032 SHALL cover: Reset pulsed mid-debounce while in PAUSE -> all outputs 0, State=00 asynchronously; no pulse emitted afterwards for the aborted press until 6 edges of held-low input.
REQ-033 SHALL cover: macro undefined, Run low at edge 0 -> Run_Pulse at edge 2; a 1-cycle glitch lasting at least one synchronized sample produces a pulse.
